// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and serial_adder.
// Carries the sub select only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder plus a carry flop, LSB first, WIDTH+2 cycles per op.
// Optional subtract mode (b inverted, carry seeded with 1) under SERIAL_ADDER_SUB_EN.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic            clk_i,
  input logic            rst_i,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a_i     (opa_q[0]),
    .b_i     (opb_q[0]),
    .c_i     (carry_q),
    .sum_o   (fa_s),
    .carry_o (fa_co)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's complement subtract: a + ~b + 1
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          opb_d   = bus.b;
          carry_d = bus.cin;
`endif
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_d = fa_co;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        // Counter holds at terminal count so it never wraps
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, acc_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == SHIFT) || (state_q == DONE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), immediate assertions per check.
module tb_serial_adder;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   seen [8];

  serial_adder_if #(.WIDTH(8)) sa ();

  serial_adder #(.WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record full_adder input rows seen while shifting
  always @(negedge clk) begin
    if (sa.busy && !sa.done)
      seen[{dut.u_fa.a_i, dut.u_fa.b_i, dut.u_fa.c_i}] = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue one start pulse, then observe 20 cycles after the accepting edge.
  task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                    input logic [7:0] hold_val, output int done_at, output int busy_n,
                    output int done_n, output bit hold_ok);
    done_at = -1;
    busy_n  = 0;
    done_n  = 0;
    hold_ok = 1'b1;
    sa.a     = ta;
    sa.b     = tb_v;
    sa.cin   = tc;
    sa.start = 1'b1;
    tick();
    sa.start = 1'b0;
    sa.a     = 8'h00;
    sa.b     = 8'h00;
    sa.cin   = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (sa.busy) busy_n++;
      if (sa.done) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      if (j < 8 && sa.sum !== hold_val) hold_ok = 1'b0;
      tick();
    end
  endtask

  initial begin
    int done_at, busy_n, done_n;
    bit hold_ok;
    int dq[$];

    rst = 1'b1;
    sa.start = 1'b0;
    sa.a = 8'h00;
    sa.b = 8'h00;
    sa.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sa.sub = 1'b0;
`endif
    @(negedge clk);
    do_reset();
    check("rst_busy", sa.busy, 1'b0);
    check("rst_done", sa.done, 1'b0);
    check("rst_sum",  sa.sum,  8'h00);
    check("rst_cout", sa.cout, 1'b0);

    // 1: 05+03
    op(8'h05, 8'h03, 1'b0, 8'h00, done_at, busy_n, done_n, hold_ok);
    check("t1_sum",     sa.sum,  8'h08);
    check("t1_cout",    sa.cout, 1'b0);
    check("t1_done_at", done_at, 8);
    check("t1_done_n",  done_n,  1);
    check("t1_busy_n",  busy_n,  9);
    check("t1_hold0",   hold_ok, 1'b1);

    // 3: result holds during SHIFT, then updates
    op(8'h10, 8'h20, 1'b0, 8'h08, done_at, busy_n, done_n, hold_ok);
    check("t3_hold08", hold_ok, 1'b1);
    check("t3_sum",    sa.sum,  8'h30);
    check("t3_cout",   sa.cout, 1'b0);

    // 2: full carry ripple
    do_reset();
    op(8'hFF, 8'h01, 1'b0, 8'h00, done_at, busy_n, done_n, hold_ok);
    check("t2a_sum",  sa.sum,  8'h00);
    check("t2a_cout", sa.cout, 1'b1);
    do_reset();
    op(8'hFF, 8'hFF, 1'b1, 8'h00, done_at, busy_n, done_n, hold_ok);
    check("t2b_sum",  sa.sum,  8'hFF);
    check("t2b_cout", sa.cout, 1'b1);
    op(8'h3C, 8'h0F, 1'b1, 8'hFF, done_at, busy_n, done_n, hold_ok);
    check("t2c_sum",  sa.sum,  8'h4C);
    check("t2c_cout", sa.cout, 1'b0);

    // 4: start held high -> one op per 10 cycles
    do_reset();
    sa.a = 8'h01;
    sa.b = 8'h01;
    sa.cin = 1'b0;
    sa.start = 1'b1;
    tick();
    for (int j = 0; j < 40; j++) begin
      if (sa.done) dq.push_back(j);
      tick();
    end
    sa.start = 1'b0;
    check("t4_pulses", dq.size(), 4);
    if (dq.size() == 4) begin
      check("t4_d0", dq[0], 8);
      check("t4_d1", dq[1], 18);
      check("t4_d2", dq[2], 28);
      check("t4_d3", dq[3], 38);
    end
    repeat (12) tick();
    check("t4_sum",  sa.sum,  8'h02);
    check("t4_cout", sa.cout, 1'b0);

    // 5: reset mid-op discards the partial result
    do_reset();
    op(8'h05, 8'h03, 1'b0, 8'h00, done_at, busy_n, done_n, hold_ok);
    sa.a = 8'hAA;
    sa.b = 8'h55;
    sa.start = 1'b1;
    tick();
    sa.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", sa.busy, 1'b0);
    check("t5_done", sa.done, 1'b0);
    check("t5_sum",  sa.sum,  8'h00);
    check("t5_cout", sa.cout, 1'b0);
    done_n = 0;
    for (int j = 0; j < 15; j++) begin
      if (sa.done || sa.busy) done_n++;
      tick();
    end
    check("t5_quiet", done_n, 0);

`ifdef SERIAL_ADDER_SUB_EN
    // 6: subtract mode
    do_reset();
    sa.sub = 1'b1;
    op(8'h05, 8'h07, 1'b0, 8'h00, done_at, busy_n, done_n, hold_ok);
    check("t6a_sum",  sa.sum,  8'hFE);
    check("t6a_cout", sa.cout, 1'b0);
    do_reset();
    sa.sub = 1'b1;
    op(8'h07, 8'h05, 1'b0, 8'h00, done_at, busy_n, done_n, hold_ok);
    check("t6b_sum",  sa.sum,  8'h02);
    check("t6b_cout", sa.cout, 1'b1);
    sa.sub = 1'b0;
`endif

    for (int r = 0; r < 8; r++) check($sformatf("fa_row%0d", r), seen[r], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
